assembly_multi: RTL and testbench
=================================

# assembly_multi

Parametrised successor of the serial package assembler: decodes three one-hot symbol lines (head / zero / one), each symbol `SYM_LEN` clock cycles long, into `DATA_W`-bit packages. It sits between the line front-end and the package consumer. Compared with the fixed 28-bit assembler, it adds:
- configurable symbol length and package width,
- run-length symbol splitting,
- resynchronisation on an unexpected head,
- an inter-symbol timeout,
- error reporting with a saturating error counter.

## Interface
- `DATA_W`, 28: package width in bits; range 1..64.
- `SYM_LEN`, 2: cycles per symbol; range 1..15.
- `TIMEOUT`, 16: enabled cycles without a recognised symbol before the block aborts a frame in COLLECT; must be > `SYM_LEN`.
- `ERR_W`, 8: error counter width.

Ports:
- `i_clk`  in  1: single clock, rising edge.
- `i_rst_n`  in  1: reset, asynchronous, active-low.
- `i_ena`  in  1: global enable. When low, all state freezes.
- `i_zero`, `i_one`, `i_head`  in  1 each: symbol lines, one-hot per cycle.
- `o_package`  out  `DATA_W`: last completed package, MSB received first; held until the next completion.
- `o_ready`  out  1: one-cycle pulse when `o_package` updates.
- `o_err`  out  1: one-cycle error pulse.
- `o_err_code`  out  2: cause of the last error, held. 1 = illegal, 2 = head resync, 3 = timeout.
- `o_err_cnt`  out  `ERR_W`: count of error pulses, saturating at all-ones.
- `o_busy`  out  1: high while in COLLECT.

## Operation
- **Input stage:** inputs are registered once (stage S1). All decoding below uses the S1 values.
- **Run counters:** one per line, width 4.
  - Clear when the line is low.
  - Increment when the line is high and the other two lines are low.
  - When the increment reaches `SYM_LEN`: fire the symbol strobe for that line and reload to 0. A run of 2·`SYM_LEN` therefore yields two symbols.
  - A trailing partial run shorter than `SYM_LEN` is discarded silently.
- **Illegal cycle:** two or more lines high in S1.
  - Clears all run counters and fires no symbol.
  - In COLLECT: `o_err` with code 1, go to IDLE.
  - In IDLE: ignored, no error.
- **States:**
  - IDLE: head strobe → COLLECT. Clear the bit counter, clear the timeout counter. Zero/one strobes are ignored.
  - COLLECT:
    - zero/one strobe: shift 0/1 into the shift register from the LSB side, increment the bit counter, clear the timeout counter.
    - When the bit counter reaches `DATA_W`: copy the shift register to `o_package`, pulse `o_ready`, go to IDLE.
    - Head strobe: `o_err` with code 2, clear the bit counter and shift register, clear the timeout counter, stay in COLLECT (resync).
    - Timeout counter reaches `TIMEOUT`: `o_err` with code 3, go to IDLE.
- **Priority within one cycle:** illegal > head > data > timeout.
- **`i_ena` low:**
  - S1, run counters, state, shift register, bit counter and timeout counter all hold.
  - `o_ready` and `o_err` are forced low.
  - Data outputs hold.
- **Error counter:** increments on every `o_err` pulse and saturates; it never wraps.
- **Reset:**
  - Asynchronous.
  - All counters cleared, state IDLE.
  - `o_package` = 0, `o_ready` = 0, `o_err` = 0, `o_err_code` = 0, `o_err_cnt` = 0, `o_busy` = 0.
  - A frame interrupted by reset is lost without an error pulse.

## Timing
- Edge E samples the final high cycle of a symbol into S1. At edge E+1 the strobe is acted on and the state, shift register and outputs update.
- `o_ready`, `o_err` and `o_busy` are registered and change at E+1.
- Package latency: `o_ready` is high during the cycle after E+1, i.e. 2 edges after the last symbol cycle is presented.
- Minimum frame length: (1 + `DATA_W`)·`SYM_LEN` enabled cycles. Back-to-back frames need no gap: a head may start in the cycle immediately after the last data symbol.
- Timeout counts enabled cycles only and includes cycles spent in partial runs.
- `o_busy` rises at E+1 of the head symbol and falls at E+1 of the completion or abort.

## Test plan
- **Basic frame:** default parameters, head run of 2 cycles, then 28 symbols encoding 28'hA5C3F01 (2 cycles each, no gaps) → single `o_ready` pulse, `o_package` = 28'hA5C3F01, 2 edges after the last symbol cycle. `o_err` never pulses.
- **Run splitting and partial runs:** `i_one` held 4 cycles → two '1' bits. A 1-cycle `i_zero` glitch between symbols is discarded → same package as the clean stimulus.
- **Illegal cycle:** `i_zero` and `i_one` high together at bit 10 → `o_err` pulse, `o_err_code` = 1, `o_busy` falls, no `o_ready`, `o_err_cnt` = 1. A following clean frame decodes correctly.
- **Resync:** head symbol after 5 bits, then 28 bits of 28'h0000FFF → `o_err` code 2, then `o_ready` with 28'h0000FFF.
- **Timeout:** head, 3 bits, then 16 idle cycles → `o_err` code 3 at the 16th idle cycle, state IDLE. With `ERR_W` = 2 and 5 timeouts in a row → `o_err_cnt` saturates at 3.
- **Enable and reset:** `i_ena` low for 7 cycles mid-symbol → decoding resumes as if uninterrupted, correct package. `i_rst_n` asserted mid-frame → all outputs 0 immediately, next frame correct.

Source files
------------

// File: rtl/assembly_multi.sv
// assembly_multi: decodes three one-hot symbol lines (head / zero / one),
// SYM_LEN cycles per symbol, into DATA_W-bit packages. Runs longer than one
// symbol split into several symbols; partial runs are dropped. Frames abort
// on illegal cycles and on timeout, and resync on an unexpected head.
module assembly_multi #(
    parameter int DATA_W  = 28,
    parameter int SYM_LEN = 2,
    parameter int TIMEOUT = 16,
    parameter int ERR_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ena,
    input  logic              i_zero,
    input  logic              i_one,
    input  logic              i_head,
    output logic [DATA_W-1:0] o_package,
    output logic              o_ready,
    output logic              o_err,
    output logic [1:0]        o_err_code,
    output logic [ERR_W-1:0]  o_err_cnt,
    output logic              o_busy
);
    localparam int BC_W = $clog2(DATA_W + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [3:0] SL = 4'(SYM_LEN);

    // line index: 0 = zero, 1 = one, 2 = head
    typedef enum logic {S_IDLE, S_COLLECT} state_t;

    state_t            r_state;
    logic [2:0]        r_s1;
    logic [2:0][3:0]   r_run;
    logic [DATA_W-1:0] r_shift;
    logic [BC_W-1:0]   r_bitcnt;
    logic [TO_W-1:0]   r_tcnt;
    logic [DATA_W-1:0] r_package;
    logic              r_ready;
    logic              r_err;
    logic [1:0]        r_err_code;
    logic [ERR_W-1:0]  r_err_cnt;

    logic              w_illegal;
    logic [2:0]        w_solo;
    logic [2:0]        w_stb;
    logic [2:0][3:0]   w_run_nxt;
    logic              w_data;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [TO_W-1:0]   w_tcnt_inc;
    logic              w_err;
    logic [1:0]        w_err_code;

    // Symbol recognition on the registered line values
    always_comb begin
        w_illegal = (r_s1[0] & r_s1[1]) | (r_s1[0] & r_s1[2]) | (r_s1[1] & r_s1[2]);
        // with at most one line high, "line alone" is just the line itself
        w_solo    = w_illegal ? 3'b000 : r_s1;
        w_stb     = 3'b000;
        w_run_nxt = '0;
        for (int l = 0; l < 3; l++) begin
            if (w_solo[l]) begin
                if (r_run[l] + 4'd1 == SL) w_stb[l] = 1'b1;
                else                       w_run_nxt[l] = r_run[l] + 4'd1;
            end
        end
        w_data      = w_stb[0] | w_stb[1];
        w_shift_nxt = (r_shift << 1) | DATA_W'(w_stb[1]);
        w_tcnt_inc  = r_tcnt + 1'b1;
    end

    // Error cause for this cycle, ordered illegal > head > data > timeout
    always_comb begin
        w_err      = 1'b0;
        w_err_code = 2'd0;
        if (r_state == S_COLLECT) begin
            if (w_illegal) begin
                w_err = 1'b1; w_err_code = 2'd1;
            end else if (w_stb[2]) begin
                w_err = 1'b1; w_err_code = 2'd2;
            end else if (!w_data && w_tcnt_inc == TO_W'(TIMEOUT)) begin
                w_err = 1'b1; w_err_code = 2'd3;
            end
        end
    end

    // Input register and run counters, frozen while disabled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1  <= '0;
            r_run <= '0;
        end else if (i_ena) begin
            r_s1  <= {i_head, i_one, i_zero};
            r_run <= w_run_nxt;
        end
    end

    // Frame FSM with registered ready/error pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_tcnt     <= '0;
            r_package  <= '0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            if (i_ena) begin
                if (w_err) begin
                    r_err      <= 1'b1;
                    r_err_code <= w_err_code;
                end
                case (r_state)
                    S_IDLE: begin
                        if (w_stb[2]) begin
                            r_state  <= S_COLLECT;
                            r_shift  <= '0;
                            r_bitcnt <= '0;
                            r_tcnt   <= '0;
                        end
                    end
                    S_COLLECT: begin
                        if (w_illegal) begin
                            r_state <= S_IDLE;
                        end else if (w_stb[2]) begin
                            // resync: restart the frame on the new head
                            r_shift  <= '0;
                            r_bitcnt <= '0;
                            r_tcnt   <= '0;
                        end else if (w_data) begin
                            r_shift <= w_shift_nxt;
                            r_tcnt  <= '0;
                            if (r_bitcnt == BC_W'(DATA_W - 1)) begin
                                r_package <= w_shift_nxt;
                                r_ready   <= 1'b1;
                                r_bitcnt  <= '0;
                                r_state   <= S_IDLE;
                            end else begin
                                r_bitcnt <= r_bitcnt + 1'b1;
                            end
                        end else if (w_err) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_tcnt <= w_tcnt_inc;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Saturating count of error pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                    r_err_cnt <= '0;
        else if (i_ena && w_err && r_err_cnt != '1)     r_err_cnt <= r_err_cnt + 1'b1;
    end

    assign o_package  = r_package;
    assign o_ready    = r_ready;
    assign o_err      = r_err;
    assign o_err_code = r_err_code;
    assign o_err_cnt  = r_err_cnt;
    assign o_busy     = (r_state == S_COLLECT);
endmodule

// File: tb/tb_assembly_multi.sv
// Bench for assembly_multi: directed scenarios plus randomized frames, checked
// by a scoreboard fed from a symbol-level reference model.
module tb_assembly_multi;
    localparam int DW = 28;
    localparam int SL = 2;
    localparam int TO = 16;

    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
    logic z = 1'b0, o = 1'b0, h = 1'b0;
    logic [DW-1:0] pkg, pkg2;
    logic rdy, err, busy, rdy2, err2, busy2;
    logic [1:0] code, code2;
    logic [7:0] cnt;
    logic [1:0] cnt2;

    assembly_multi #(.DATA_W(DW), .SYM_LEN(SL), .TIMEOUT(TO), .ERR_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_zero(z), .i_one(o), .i_head(h),
        .o_package(pkg), .o_ready(rdy), .o_err(err), .o_err_code(code),
        .o_err_cnt(cnt), .o_busy(busy));

    assembly_multi #(.DATA_W(DW), .SYM_LEN(SL), .TIMEOUT(TO), .ERR_W(2)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_zero(z), .i_one(o), .i_head(h),
        .o_package(pkg2), .o_ready(rdy2), .o_err(err2), .o_err_code(code2),
        .o_err_cnt(cnt2), .o_busy(busy2));

    always #5 clk = ~clk;

    typedef struct {
        bit      is_err;
        int      code;
        longint  pkg;
        int      cnt;
    } ev_t;
    ev_t sb[$];

    int n_cmp = 0, n_bad = 0;
    bit g_rnd_ena = 0;

    // reference model state
    int     m_run[3];
    bit     m_coll;
    int     m_bits, m_since, m_cnt;
    longint m_pkg;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_err(int c);
        ev_t e;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        e.is_err = 1; e.code = c; e.pkg = 0; e.cnt = m_cnt;
        sb.push_back(e);
    endfunction

    function automatic void model_reset();
        for (int l = 0; l < 3; l++) m_run[l] = 0;
        m_coll = 0; m_bits = 0; m_since = 0; m_cnt = 0; m_pkg = 0;
        sb.delete();
    endfunction

    // One enabled input cycle, interpreted with the frame rules directly
    function automatic void model(bit zz, bit oo, bit hh);
        bit line[3];
        int nh, sym;
        ev_t e;
        line[0] = zz; line[1] = oo; line[2] = hh;
        nh = int'(zz) + int'(oo) + int'(hh);
        sym = -1;
        for (int l = 0; l < 3; l++) begin
            if (nh == 1 && line[l]) begin
                m_run[l]++;
                if (m_run[l] == SL) begin sym = l; m_run[l] = 0; end
            end else m_run[l] = 0;
        end
        if (nh > 1) begin
            if (m_coll) push_err(1);
            m_coll = 0;
        end else if (sym == 2) begin
            if (m_coll) push_err(2);
            m_coll = 1; m_bits = 0; m_pkg = 0; m_since = 0;
        end else if (sym >= 0) begin
            if (m_coll) begin
                m_pkg = m_pkg * 2 + sym;
                m_bits++;
                m_since = 0;
                if (m_bits == DW) begin
                    e.is_err = 0; e.code = 0; e.pkg = m_pkg; e.cnt = 0;
                    sb.push_back(e);
                    m_coll = 0;
                end
            end
        end else if (m_coll) begin
            m_since++;
            if (m_since == TO) begin push_err(3); m_coll = 0; end
        end
    endfunction

    task automatic stall(int n);
        repeat (n) begin
            ena = 1'b0;
            z = 1'($urandom_range(1)); o = 1'($urandom_range(1)); h = 1'($urandom_range(1));
            @(negedge clk);
        end
    endtask

    task automatic tick(bit zz, bit oo, bit hh);
        if (g_rnd_ena && $urandom_range(7) == 0) stall(1);
        ena = 1'b1; z = zz; o = oo; h = hh;
        model(zz, oo, hh);
        @(negedge clk);
    endtask

    task automatic idle(int n);
        repeat (n) tick(0, 0, 0);
    endtask

    task automatic sym(int k);
        for (int c = 0; c < SL; c++) tick(k == 0, k == 1, k == 2);
    endtask

    task automatic rbits(int n);
        repeat (n) sym(int'($urandom_range(1)));
    endtask

    // head + DW data symbols; optional zero glitches between adjacent ones,
    // optional 7-cycle disable inside bit stall_bit
    task automatic frame(logic [DW-1:0] p, bit glitch, int stall_bit);
        sym(2);
        for (int i = DW - 1; i >= 0; i--) begin
            bit b;
            b = p[i];
            if (glitch && i < DW - 1 && b && p[i+1]) tick(1, 0, 0);
            if (i == stall_bit) begin
                tick(!b, b, 0);
                stall(7);
                for (int k = 1; k < SL; k++) tick(!b, b, 0);
            end else sym(int'(b));
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && (rdy || err)) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_event: rdy=%0b err=%0b code=%0d pkg=%0h", rdy, err, code, pkg);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("event_kind", 64'(err), 64'(e.is_err));
                if (e.is_err) begin
                    chk("err_code", 64'(code), 64'(e.code));
                    chk("err_cnt", 64'(cnt), 64'(e.cnt));
                    chk("err_cnt_sat", 64'(cnt2), 64'((e.cnt > 3) ? 3 : e.cnt));
                end else begin
                    chk("package", 64'(pkg), 64'(e.pkg));
                    chk("package_w2", 64'(pkg2), 64'(e.pkg));
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] p;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_package", 64'(pkg), 0);
        chk("rst_ready", 64'(rdy), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_code", 64'(code), 0);
        chk("rst_cnt", 64'(cnt), 0);
        chk("rst_busy", 64'(busy), 0);
        rst_n = 1'b1;
        idle(2);

        // basic frame with exact latency
        frame(28'hA5C3F01, 0, -1);
        chk("busy_before_done", 64'(busy), 1);
        chk("ready_early", 64'(rdy), 0);
        idle(1);
        chk("ready_latency", 64'(rdy), 1);
        chk("basic_package", 64'(pkg), 64'(28'hA5C3F01));
        idle(1);
        chk("busy_after_done", 64'(busy), 0);
        idle(2);

        // glitches between ones, long runs split into several bits
        frame(28'hA5C3F01, 1, -1);
        idle(3);
        frame(28'hF0F0F0F, 1, -1);
        idle(3);

        // illegal cycle at bit 10
        sym(2); rbits(10);
        tick(1, 1, 0);
        idle(1);
        chk("illegal_err", 64'(err), 1);
        chk("illegal_code", 64'(code), 1);
        chk("illegal_busy", 64'(busy), 0);
        chk("illegal_cnt", 64'(cnt), 1);
        idle(2);
        frame(28'h1234567, 0, -1);
        idle(3);

        // resync
        sym(2); rbits(5);
        frame(28'h0000FFF, 0, -1);
        idle(3);
        chk("resync_code_held", 64'(code), 2);
        chk("resync_package", 64'(pkg), 64'(28'h0000FFF));

        // timeout, then repeated timeouts to saturate the narrow counter
        sym(2); rbits(3);
        idle(TO);
        idle(1);
        chk("timeout_err", 64'(err), 1);
        chk("timeout_code", 64'(code), 3);
        chk("timeout_busy", 64'(busy), 0);
        repeat (5) begin sym(2); idle(TO + 2); end
        chk("sat_cnt", 64'(cnt2), 3);
        chk("wide_cnt", 64'(cnt), 64'(m_cnt));

        // enable low mid-symbol
        p = DW'($urandom);
        frame(p, 0, 13);
        idle(3);
        chk("ena_package", 64'(pkg), 64'(p));

        // reset mid-frame
        sym(2); rbits(10);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_package", 64'(pkg), 0);
        chk("midrst_ready", 64'(rdy), 0);
        chk("midrst_err", 64'(err), 0);
        chk("midrst_code", 64'(code), 0);
        chk("midrst_cnt", 64'(cnt), 0);
        chk("midrst_busy", 64'(busy), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        p = DW'($urandom);
        frame(p, 0, -1);
        idle(3);
        chk("post_rst_package", 64'(pkg), 64'(p));

        // randomized traffic with random disable cycles
        g_rnd_ena = 1;
        repeat (30) begin
            int kind;
            kind = int'($urandom_range(9));
            if (kind == 0) begin
                sym(2); rbits(int'($urandom_range(DW - 1))); tick(1, 1, 0);
            end else if (kind == 1) begin
                sym(2); rbits(int'($urandom_range(DW - 1))); idle(TO + 2);
            end else if (kind == 2) begin
                sym(2); rbits(int'($urandom_range(DW - 1)));
                frame(DW'($urandom), 1, -1);
            end else begin
                frame(DW'($urandom), 1'($urandom_range(1)), -1);
            end
            idle(int'($urandom_range(3)));
        end
        g_rnd_ena = 0;
        idle(5);
        chk("scoreboard_drained", 64'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
